// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS bit positions and TX FSM encoding shared by
// the MMIO UART transmitter and its bench-facing documentation.
package uart_pkg;

  // Word offsets inside the 4-word register window (addr[1:0]).
  localparam logic [1:0] OFF_DATA    = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_DIVISOR = 2'd2;
  localparam logic [1:0] OFF_RSVD    = 2'd3;

  // STATUS register bit positions.
  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  // Data bits per 8N1 frame.
  localparam int DATA_BITS = 8;

  // Transmitter line state.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Pack the STATUS word; unused upper bits read as zero.
  function automatic logic [31:0] make_status(
    input logic busy,
    input logic full,
    input logic empty,
    input logic ovf
  );
    logic [31:0] w;
    w           = '0;
    w[ST_BUSY]  = busy;
    w[ST_FULL]  = full;
    w[ST_EMPTY] = empty;
    w[ST_OVF]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO. Head entry is visible on dout
// while not empty; push and pop may coincide at any fill level (a push into
// a full FIFO is accepted only when a pop frees a slot on the same edge).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_q];

  // Next pointer and occupancy values from the accepted push/pop pair.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter. Decodes a 4-word window
// (DATA, STATUS, DIVISOR, reserved), queues written bytes in a FIFO and
// shifts them out on txd with a bit period of DIVISOR+1 clocks. Read data is
// registered and forced to zero when the window is not read, so it can be
// OR-combined with the other bus slaves.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [29:0] BASE      = 30'h3FFF_FFF0,
  parameter int          DEPTH     = 4,
  parameter logic [15:0] DIV_RESET = 16'd103
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  // Bus decode
  logic        sel;
  logic [1:0]  offset;
  logic        data_wr;
  logic        status_wr;
  logic        div_wr_lo;
  logic        div_wr_hi;
  logic        ovf_set;
  logic [31:0] status_word;

  // Only the low two byte lanes carry register bits.
  logic        unused_bus_bits;

  // Registers
  logic        overflow_q, overflow_d;
  logic [15:0] divisor_q, divisor_d;
  logic [31:0] rdata_q, rdata_d;

  // Transmitter
  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        busy;
  logic        baud_zero;

  // FIFO interface
  logic        fifo_pop;
  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;

  assign sel       = (addr[29:2] == BASE[29:2]);
  assign offset    = addr[1:0];
  assign data_wr   = sel && we[0] && (offset == OFF_DATA);
  assign status_wr = sel && we[0] && (offset == OFF_STATUS);
  assign div_wr_lo = sel && we[0] && (offset == OFF_DIVISOR);
  assign div_wr_hi = sel && we[1] && (offset == OFF_DIVISOR);

  // A byte is lost only when the FIFO is full and nothing leaves this edge.
  assign ovf_set   = data_wr && fifo_full && !fifo_pop;

  assign busy        = (state_q != TX_IDLE);
  assign baud_zero   = (baud_q == '0);
  assign status_word = make_status(busy, fifo_full, fifo_empty, overflow_q);

  assign unused_bus_bits = ^{we[3:2], wdata[31:16]};

  assign rdata = rdata_q;
  assign txd   = txd_q;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (data_wr),
    .din   (wdata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Register writes and read-data mux (reads see pre-write values).
  always_comb begin
    overflow_d = overflow_q;
    if (status_wr && wdata[ST_OVF]) begin
      overflow_d = 1'b0;
    end
    if (ovf_set) begin
      overflow_d = 1'b1;
    end

    divisor_d = divisor_q;
    if (div_wr_lo) begin
      divisor_d[7:0] = wdata[7:0];
    end
    if (div_wr_hi) begin
      divisor_d[15:8] = wdata[15:8];
    end

    rdata_d = '0;
    if (sel && re) begin
      case (offset)
        OFF_STATUS:         rdata_d = status_word;
        OFF_DIVISOR:        rdata_d = {16'h0000, divisor_q};
        OFF_DATA, OFF_RSVD: rdata_d = '0;
        default:            rdata_d = '0;
      endcase
    end
  end

  // Bus-side registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      divisor_q  <= DIV_RESET;
      rdata_q    <= '0;
    end else begin
      overflow_q <= overflow_d;
      divisor_q  <= divisor_d;
      rdata_q    <= rdata_d;
    end
  end

  // Transmitter next-state: baud countdown, bit sequencing and FIFO pop.
  // The line level for the next bit period is computed here so txd is a flop.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    fifo_pop  = 1'b0;

    case (state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_dout;
          bit_cnt_d = '0;
          baud_d    = divisor_q;
          state_d   = TX_START;
          txd_d     = 1'b0;
        end
      end

      TX_START: begin
        if (baud_zero) begin
          baud_d  = divisor_q;
          state_d = TX_DATA;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      TX_DATA: begin
        if (baud_zero) begin
          baud_d = divisor_q;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = TX_STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      TX_STOP: begin
        if (baud_zero) begin
          if (!fifo_empty) begin
            // Chain straight into the next frame without an idle bit.
            fifo_pop  = 1'b1;
            shift_d   = fifo_dout;
            bit_cnt_d = '0;
            baud_d    = divisor_q;
            state_d   = TX_START;
            txd_d     = 1'b0;
          end else begin
            state_d = TX_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      default: begin
        state_d = TX_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // Transmitter state registers; reset forces the line high at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= TX_IDLE;
      baud_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed + randomized bench for the MMIO UART transmitter.
// Expected line waveforms are built from the frame format (start, 8 data bits
// LSB first, stop, each held for the bit period) and compared as whole vectors.
module tb_uart_tx_mmio;

  localparam logic [29:0] BASE = 30'h3FFF_FFF0;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        txd;

  int errors = 0;
  int checks = 0;

  logic [127:0] exp_v;
  logic [127:0] act_v;
  int           exp_len;

  logic [31:0] rd;
  logic [31:0] exp_st;
  logic [7:0]  b;
  logic [7:0]  bytes [5];
  int          d;
  int          occ;
  int          dropped;
  logic        mpop;
  logic        accept;

  always #5 clk = ~clk;

  uart_tx_mmio dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .re    (re),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .txd   (txd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_wave(input string tag);
    checks++;
    $display("frame %s cycles=%0d", tag, exp_len);
    assert (act_v === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, act_v, exp_v);
    end
  endtask

  function automatic logic [29:0] reg_addr(input logic [1:0] off);
    return {BASE[29:2], off};
  endfunction

  // Called at posedge+1; the write is sampled at the next rising edge.
  task automatic bus_write(input logic [1:0] off, input logic [3:0] lanes, input logic [31:0] data);
    addr  = reg_addr(off);
    we    = lanes;
    wdata = data;
    @(posedge clk);
    #1;
    we = 4'b0000;
    $display("write off=%0d we=%b data=%h", off, lanes, data);
  endtask

  // Called at posedge+1; returns rdata one cycle after the sampling edge.
  task automatic bus_read(input logic [29:0] a, output logic [31:0] data);
    addr = a;
    re   = 1'b1;
    @(posedge clk);
    #1;
    re   = 1'b0;
    data = rdata;
    $display("read addr=%h data=%h", a, data);
  endtask

  task automatic clear_model();
    exp_v   = '0;
    act_v   = '0;
    exp_len = 0;
  endtask

  task automatic add_bits(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      exp_v[exp_len] = v;
      exp_len++;
    end
  endtask

  task automatic add_frame(input logic [7:0] data, input int period);
    add_bits(1'b0, period);
    for (int i = 0; i < 8; i++) begin
      add_bits(data[i], period);
    end
    add_bits(1'b1, period);
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      act_v[i] = txd;
    end
  endtask

  initial begin
    reset = 1'b0;
    re    = 1'b0;
    we    = 4'b0000;
    wdata = '0;
    addr  = '0;

    // Power-on reset values.
    repeat (3) @(posedge clk);
    #1;
    check("por_txd", {31'b0, txd}, 32'd1);
    check("por_rdata", rdata, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus_read(reg_addr(2'd1), rd);
    check("por_status", rd, 32'h4);
    bus_read(reg_addr(2'd2), rd);
    check("por_divisor", rd, 32'd103);

    // Read timing and decode.
    bus_read(reg_addr(2'd1), rd);
    check("status_read", rd, 32'h4);
    bus_read(30'h0000_0001, rd);
    check("unselected_read", rd, 32'd0);
    bus_read(reg_addr(2'd2), rd);
    check("divisor_read", rd, 32'd103);
    @(posedge clk);
    #1;
    check("rdata_one_cycle", rdata, 32'd0);

    // DIVISOR lanes, upper bits, reserved word, DATA read.
    bus_write(2'd2, 4'b1111, 32'hFFFF_0005);
    bus_read(reg_addr(2'd2), rd);
    check("div_upper_zero", rd, 32'h0000_0005);
    bus_write(2'd2, 4'b0010, 32'h0000_AB77);
    bus_read(reg_addr(2'd2), rd);
    check("div_lane1_only", rd, 32'h0000_AB05);
    bus_write(2'd3, 4'b1111, 32'hFFFF_FFFF);
    bus_read(reg_addr(2'd3), rd);
    check("reserved_read", rd, 32'd0);
    bus_read(reg_addr(2'd2), rd);
    check("div_after_rsvd_wr", rd, 32'h0000_AB05);
    bus_read(reg_addr(2'd0), rd);
    check("data_read_zero", rd, 32'd0);

    // DATA write on lane 1 only must not push.
    bus_write(2'd0, 4'b0010, 32'h0000_5500);
    repeat (3) @(posedge clk);
    #1;
    check("lane1_no_tx", {31'b0, txd}, 32'd1);
    bus_read(reg_addr(2'd1), rd);
    check("lane1_no_push", rd, 32'h4);

    // DIVISOR=3, single 0xA5 frame.
    bus_write(2'd2, 4'b0011, 32'd3);
    clear_model();
    bus_write(2'd0, 4'b0001, 32'hA5);
    check("a5_idle_at_write", {31'b0, txd}, 32'd1);
    add_frame(8'hA5, 4);
    add_bits(1'b1, 2);
    capture(exp_len);
    check_wave("a5_frame");
    bus_read(reg_addr(2'd1), rd);
    check("a5_status_idle", rd, 32'h4);

    // Random bytes at random divisors.
    for (int k = 0; k < 3; k++) begin
      d = $urandom_range(0, 5);
      b = 8'($urandom);
      bus_write(2'd2, 4'b0011, 32'(d));
      clear_model();
      bus_write(2'd0, 4'b0001, {24'h0, b});
      add_frame(b, d + 1);
      add_bits(1'b1, 2);
      capture(exp_len);
      check_wave("rand_frame");
    end

    // Divisor change 3 -> 7 in the middle of data bit 0.
    bus_write(2'd2, 4'b0011, 32'd3);
    clear_model();
    b = 8'($urandom);
    bus_write(2'd0, 4'b0001, {24'h0, b});
    add_bits(1'b0, 4);
    add_bits(b[0], 4);
    for (int i = 1; i < 8; i++) begin
      add_bits(b[i], 8);
    end
    add_bits(1'b1, 8);
    add_bits(1'b1, 2);
    fork
      begin
        repeat (5) @(posedge clk);
        #1;
        bus_write(2'd2, 4'b0011, 32'd7);
      end
      capture(exp_len);
    join
    check_wave("div_change_frame");

    // DIVISOR=0, five back-to-back writes into a 4-deep FIFO.
    bus_write(2'd2, 4'b0011, 32'd0);
    clear_model();
    for (int k = 0; k < 5; k++) begin
      bytes[k] = 8'($urandom);
      add_frame(bytes[k], 1);
    end
    add_bits(1'b1, 2);
    bus_write(2'd0, 4'b0001, {24'h0, bytes[0]});
    fork
      begin
        for (int k = 1; k < 5; k++) begin
          bus_write(2'd0, 4'b0001, {24'h0, bytes[k]});
        end
      end
      capture(exp_len);
    join
    check_wave("burst5_frames");
    bus_read(reg_addr(2'd1), rd);
    check("burst5_no_overflow", rd, 32'h4);

    // Overflow: slow line, seven consecutive writes.
    bus_write(2'd2, 4'b0011, 32'd1000);
    occ     = 0;
    dropped = 0;
    for (int k = 0; k < 7; k++) begin
      b = 8'($urandom);
      bus_write(2'd0, 4'b0001, {24'h0, b});
      // The idle transmitter takes the first byte on the edge after it lands.
      mpop   = (k == 1) && (occ > 0);
      accept = (occ < 4) || mpop;
      occ    = occ + (accept ? 1 : 0) - (mpop ? 1 : 0);
      if (!accept) begin
        dropped++;
      end
    end
    exp_st = {28'h0, (dropped > 0), (occ == 0), (occ == 4), 1'b1};
    bus_read(reg_addr(2'd1), rd);
    check("ovf_status", rd, exp_st);
    bus_write(2'd1, 4'b0001, 32'h0);
    bus_read(reg_addr(2'd1), rd);
    check("ovf_kept_no_clear_bit", rd, exp_st);
    bus_write(2'd1, 4'b0001, 32'h8);
    exp_st[3] = 1'b0;
    bus_read(reg_addr(2'd1), rd);
    check("ovf_cleared", rd, exp_st);

    // Asynchronous reset in the middle of a start bit with rdata valid.
    check("pre_reset_txd_low", {31'b0, txd}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("reset_txd_high", {31'b0, txd}, 32'd1);
    check("reset_rdata_zero", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    bus_read(reg_addr(2'd1), rd);
    check("reset_status", rd, 32'h4);
    bus_read(reg_addr(2'd2), rd);
    check("reset_divisor", rd, 32'd103);
    clear_model();
    add_bits(1'b1, 12);
    capture(exp_len);
    check_wave("post_reset_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
